// File: rtl/rf_pkg.sv
// rf_pkg: shared register-file definitions.
// Holds the architectural data/index widths and types used by the
// RegisterFile, the core and regfile_reader, plus the reader FSM state
// type and a helper that computes the wrap-around beat count of a sweep.
package rf_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int IDX_W = $clog2(NREGS);

  typedef logic [IDX_W-1:0] reg_idx_t;
  typedef logic [XLEN-1:0]  xlen_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } reader_state_t;

  // Number of registers from start_idx to end_idx inclusive, walking
  // upward modulo NREGS. The subtraction wraps naturally because NREGS
  // is a power of two, so a full sweep needs end_idx = start_idx - 1.
  function automatic logic [IDX_W:0] beat_count(input reg_idx_t start_idx,
                                                 input reg_idx_t end_idx);
    reg_idx_t span;
    span = end_idx - start_idx;
    return {1'b0, span} + (IDX_W + 1)'(1);
  endfunction

endpackage

// File: rtl/regfile_reader_fifo.sv
// regfile_reader_fifo: small synchronous FIFO of {register index, data}
// beats that decouples the fixed-latency register read from the consumer.
// Ports:
//   clk, rst            clock, synchronous active-low reset (flushes FIFO)
//   push, push_idx/data write a beat (accepted when not full or popping)
//   pop                 remove the head beat (ignored when empty)
//   head_idx/head_data  current head beat (meaningful when !empty)
//   count, full, empty  occupancy status
module regfile_reader_fifo
  import rf_pkg::*;
#(
  parameter int BUF_DEPTH = 2,
  parameter int CNT_W     = $clog2(BUF_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [IDX_W-1:0] push_idx,
  input  logic [XLEN-1:0]  push_data,
  input  logic             pop,
  output logic [IDX_W-1:0] head_idx,
  output logic [XLEN-1:0]  head_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int               PTR_W     = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(BUF_DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(BUF_DEPTH);

  logic [PTR_W-1:0] wptr_reg;
  logic [PTR_W-1:0] rptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [IDX_W-1:0] idx_q  [BUF_DEPTH];
  logic [XLEN-1:0]  data_q [BUF_DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == DEPTH_CNT);
  assign count   = count_reg;
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is still fine when the head leaves this cycle.
  assign do_push = push && (!full || do_pop);

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] ptr);
    return (ptr == LAST_PTR) ? '0 : ptr + PTR_W'(1);
  endfunction

  // Storage entries; each one only loads when the write pointer selects it.
  genvar gi;
  generate
    for (gi = 0; gi < BUF_DEPTH; gi++) begin : g_entry
      logic [IDX_W-1:0] idx_reg;
      logic [XLEN-1:0]  data_reg;

      always_ff @(posedge clk) begin
        if (!rst) begin
          idx_reg  <= '0;
          data_reg <= '0;
        end else if (do_push && (wptr_reg == PTR_W'(gi))) begin
          idx_reg  <= push_idx;
          data_reg <= push_data;
        end
      end

      assign idx_q[gi]  = idx_reg;
      assign data_q[gi] = data_reg;
    end
  endgenerate

  assign head_idx  = idx_q[rptr_reg];
  assign head_data = data_q[rptr_reg];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (do_push) wptr_reg <= bump(wptr_reg);
      if (do_pop)  rptr_reg <= bump(rptr_reg);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/regfile_reader.sv
// regfile_reader: sweeps a wrap-around range of register indices through
// the RegisterFile's synchronous read port and streams (index, data) beats
// over a valid/ready interface.
// Ports:
//   clk, rst             clock, synchronous active-low reset (aborts sweep)
//   start                begin a sweep (accepted only in IDLE)
//   first_idx, last_idx  inclusive index range, sampled on accepted start
//   busy, done           sweep in progress / one-cycle completion pulse
//   rsel, rdata          read select out, read data back one cycle later
//   out_valid/ready      beat handshake; out_idx/out_data carry the beat
module regfile_reader
  import rf_pkg::*;
#(
  parameter int BUF_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [IDX_W-1:0] first_idx,
  input  logic [IDX_W-1:0] last_idx,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] rsel,
  input  logic [XLEN-1:0]  rdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic [XLEN-1:0]  out_data
);

  localparam int             CNT_W     = $clog2(BUF_DEPTH + 1);
  localparam logic [CNT_W:0] DEPTH_OCC = (CNT_W + 1)'(BUF_DEPTH);

  reader_state_t    state_reg;
  logic [IDX_W-1:0] cur_reg;
  logic [IDX_W:0]   remaining_reg;
  logic [IDX_W-1:0] rsel_reg;
  logic             inflight_reg;
  logic [IDX_W-1:0] inflight_idx_reg;
  logic             busy_reg;
  logic             done_reg;

  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic [IDX_W-1:0] head_idx;
  logic [XLEN-1:0]  head_data;
  logic             pop;
  logic             issue;
  logic [CNT_W:0]   occupancy;
  logic [CNT_W:0]   capacity;

  // The read data is pushed one cycle after its select, tagged with the
  // index that was latched when the read was issued.
  regfile_reader_fifo #(
    .BUF_DEPTH(BUF_DEPTH),
    .CNT_W    (CNT_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (inflight_reg),
    .push_idx (inflight_idx_reg),
    .push_data(rdata),
    .pop      (pop),
    .head_idx (head_idx),
    .head_data(head_data),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // out_valid is purely a function of registered FIFO state.
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign out_idx   = fifo_empty ? '0 : head_idx;
  assign out_data  = fifo_empty ? '0 : head_data;
  assign busy      = busy_reg;
  assign done      = done_reg;

  // Credit check: every buffered beat and every read in flight owns a slot.
  // A beat leaving this cycle frees its slot immediately, which is what
  // keeps a 2-entry buffer streaming at one beat per cycle.
  always_comb begin
    occupancy = {1'b0, fifo_count} + (CNT_W + 1)'(inflight_reg);
    capacity  = DEPTH_OCC + (CNT_W + 1)'(pop);
    issue     = (state_reg == ST_ISSUE) && (occupancy < capacity) &&
                (!fifo_full || pop);
  end

  // The select only moves when a read is issued; otherwise it holds.
  assign rsel = issue ? cur_reg : rsel_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg        <= ST_IDLE;
      cur_reg          <= '0;
      remaining_reg    <= '0;
      rsel_reg         <= '0;
      inflight_reg     <= 1'b0;
      inflight_idx_reg <= '0;
      busy_reg         <= 1'b0;
      done_reg         <= 1'b0;
    end else begin
      done_reg     <= 1'b0;
      rsel_reg     <= rsel;
      inflight_reg <= issue;
      if (issue) begin
        inflight_idx_reg <= cur_reg;
        cur_reg          <= cur_reg + IDX_W'(1);
        remaining_reg    <= remaining_reg - (IDX_W + 1)'(1);
      end

      case (state_reg)
        ST_IDLE: begin
          // done_reg high means we only just left DRAIN; that start is dropped.
          if (start && !done_reg) begin
            cur_reg       <= first_idx;
            remaining_reg <= beat_count(first_idx, last_idx);
            busy_reg      <= 1'b1;
            state_reg     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (issue && (remaining_reg == (IDX_W + 1)'(1))) begin
            state_reg <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // Finish in the same cycle the final beat is handed over so done
          // appears in the very next cycle.
          if (!inflight_reg &&
              (fifo_empty || ((fifo_count == CNT_W'(1)) && pop))) begin
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_reader.sv
// tb_regfile_reader: directed, table-driven bench for regfile_reader with a
// behavioural synchronous-read register file (read-old on collision).
module tb_regfile_reader;
  import rf_pkg::*;

  localparam int BUF_DEPTH = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [IDX_W-1:0] first_idx;
  logic [IDX_W-1:0] last_idx;
  logic             busy;
  logic             done;
  logic [IDX_W-1:0] rsel;
  logic [XLEN-1:0]  rdata;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  logic [XLEN-1:0]  out_data;

  always #5 clk = ~clk;

  regfile_reader #(.BUF_DEPTH(BUF_DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .first_idx(first_idx),
    .last_idx (last_idx),
    .busy     (busy),
    .done     (done),
    .rsel     (rsel),
    .rdata    (rdata),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_idx  (out_idx),
    .out_data (out_data)
  );

  // Register file: registered read of the pre-write contents, r0 reads 0.
  logic [XLEN-1:0]  rf_mem [NREGS];
  logic             wen;
  logic [IDX_W-1:0] wsel;
  logic [XLEN-1:0]  wdata;

  always @(posedge clk) begin
    rdata <= (rsel == '0) ? '0 : rf_mem[rsel];
    if (wen && (wsel != '0)) rf_mem[wsel] <= wdata;
  end

  // Expected register contents, maintained by the bench alongside its writes.
  logic [XLEN-1:0] exp_rf [NREGS];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [IDX_W-1:0] got_idx  [$];
  logic [XLEN-1:0]  got_data [$];
  int               got_cyc  [$];
  int               done_cnt;
  int               done_cyc;
  logic [IDX_W-1:0] cur_first;
  bit               prev_stall;
  logic [IDX_W-1:0] prev_idx;
  logic [XLEN-1:0]  prev_data;
  bit               collide_armed, collide_fired, wen_auto;
  bit               poke_on_done, start_auto;

  typedef struct {
    string            name;
    logic [IDX_W-1:0] f;
    logic [IDX_W-1:0] l;
    int               n;
  } vec_t;
  vec_t vecs [4];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // One clock: inputs were set at the preceding negedge; observe at +1,
  // let the posedge happen, return at the next negedge.
  task automatic tick();
    logic [IDX_W-1:0] span;
    int               outstanding;
    #1;
    if (wen_auto) begin wen = 1'b0; wen_auto = 1'b0; end
    if (start_auto) begin start = 1'b0; start_auto = 1'b0; end
    if (prev_stall) begin
      check("stall_valid", {63'd0, out_valid}, 64'd1);
      check("stall_idx", {59'd0, out_idx}, {59'd0, prev_idx});
      check("stall_data", {32'd0, out_data}, {32'd0, prev_data});
    end
    prev_stall = out_valid && !out_ready;
    prev_idx   = out_idx;
    prev_data  = out_data;
    if (rst && out_valid && out_ready) begin
      got_idx.push_back(out_idx);
      got_data.push_back(out_data);
      got_cyc.push_back(cyc);
      $display("beat cyc=%0d idx=%0d data=%08h", cyc, out_idx, out_data);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      if (poke_on_done) begin
        start = 1'b1; first_idx = 5'd3; last_idx = 5'd3;
        start_auto = 1'b1; poke_on_done = 1'b0;
      end
    end
    if (collide_armed && busy && (rsel == 5'd12)) begin
      wen = 1'b1; wsel = 5'd12; wdata = 32'hFFFF_0000;
      wen_auto = 1'b1; collide_armed = 1'b0; collide_fired = 1'b1;
    end
    if (rst && busy) begin
      span        = rsel - cur_first;
      outstanding = int'(span) + 1 - got_idx.size();
      checks++;
      if (outstanding > BUF_DEPTH) begin
        errors++;
        $display("FAIL outstanding: got %0d reads outstanding, required <= %0d", outstanding, BUF_DEPTH);
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic write_reg(input logic [IDX_W-1:0] a, input logic [XLEN-1:0] v);
    wen = 1'b1; wsel = a; wdata = v;
    exp_rf[a] = v;
    tick();
    wen = 1'b0;
  endtask

  // mode 0: out_ready=1; mode 1: stall window + pattern; mode 2: ready=1 with
  // a start pulse mid-sweep and another in the done cycle.
  task automatic sweep_check(input string tag, input logic [IDX_W-1:0] f,
                             input logic [IDX_W-1:0] l, input int n, input int mode);
    int               s;
    int               lat;
    logic [IDX_W-1:0] e_idx;
    got_idx.delete(); got_data.delete(); got_cyc.delete();
    done_cnt  = 0;
    cur_first = f;
    out_ready = 1'b1; first_idx = f; last_idx = l; start = 1'b1;
    s = cyc;
    tick();
    start = 1'b0;
    for (int c = 0; c < 400 && done_cnt == 0; c++) begin
      if (mode == 1) out_ready = !(((c >= 4) && (c < 14)) || ((c % 3) == 2));
      else out_ready = 1'b1;
      if (mode == 2) begin
        if (c == 0) poke_on_done = 1'b1;
        if (c == 5) begin start = 1'b1; first_idx = 5'd3; last_idx = 5'd3; end
        else if (c == 6) start = 1'b0;
      end
      tick();
    end
    $display("sweep %s first=%0d last=%0d beats=%0d done=%0d", tag, f, l, got_idx.size(), done_cnt);
    check({tag, ":done_seen"}, 64'(done_cnt), 64'd1);
    check({tag, ":beat_count"}, 64'(got_idx.size()), 64'(n));
    for (int k = 0; k < got_idx.size() && k < n; k++) begin
      e_idx = f + IDX_W'(k);
      check({tag, ":idx"}, {59'd0, got_idx[k]}, {59'd0, e_idx});
      check({tag, ":data"}, {32'd0, got_data[k]}, {32'd0, exp_rf[e_idx]});
      if (mode != 1) check({tag, ":no_gap"}, 64'(got_cyc[k] - got_cyc[0]), 64'(k));
    end
    if (got_idx.size() > 0) begin
      if (mode != 1) begin
        lat = got_cyc[0] - s;
        checks++;
        if (lat > 3) begin
          errors++;
          $display("FAIL %s:first_latency got %0d cycles, required <= 3", tag, lat);
        end
      end
      if (done_cnt > 0) check({tag, ":done_timing"}, 64'(done_cyc), 64'(got_cyc[got_cyc.size()-1] + 1));
    end
    out_ready = 1'b1;
    repeat (4) tick();
    check({tag, ":post_beats"}, 64'(got_idx.size()), 64'(n));
    check({tag, ":post_done"}, 64'(done_cnt), 64'd1);
    check({tag, ":post_busy"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; first_idx = '0; last_idx = '0; out_ready = 1'b1;
    wen = 1'b0; wsel = '0; wdata = '0;
    prev_stall = 1'b0; collide_armed = 1'b0; collide_fired = 1'b0; wen_auto = 1'b0;
    poke_on_done = 1'b0; start_auto = 1'b0; cur_first = '0; done_cnt = 0; done_cyc = 0;
    for (int i = 0; i < NREGS; i++) exp_rf[i] = '0;

    repeat (3) tick();
    check("reset:busy", {63'd0, busy}, 64'd0);
    check("reset:done", {63'd0, done}, 64'd0);
    check("reset:rsel", {59'd0, rsel}, 64'd0);
    check("reset:out_valid", {63'd0, out_valid}, 64'd0);
    check("reset:out_idx", {59'd0, out_idx}, 64'd0);
    check("reset:out_data", {32'd0, out_data}, 64'd0);
    rst = 1'b1;

    for (int i = 1; i < NREGS; i++) write_reg(IDX_W'(i), 32'h1000_0000 + i);
    sweep_check("full_dump", 5'd0, 5'd31, 32, 0);

    write_reg(5'd30, 32'hAAAA_0030);
    write_reg(5'd31, 32'h1234_5678);
    write_reg(5'd1,  32'hDEAD_BEEF);
    write_reg(5'd12, 32'hAAAA_5555);

    vecs[0] = '{name: "wrap",      f: 5'd30, l: 5'd1,  n: 4};
    vecs[1] = '{name: "single",    f: 5'd7,  l: 5'd7,  n: 1};
    vecs[2] = '{name: "wrap_pair", f: 5'd31, l: 5'd0,  n: 2};
    vecs[3] = '{name: "full_rot",  f: 5'd10, l: 5'd9,  n: 32};
    for (int v = 0; v < 4; v++) sweep_check(vecs[v].name, vecs[v].f, vecs[v].l, vecs[v].n, 0);

    sweep_check("backpressure", 5'd5, 5'd9, 5, 1);

    // Write r12 in the cycle it is selected: the beat must carry the old value.
    collide_armed = 1'b1;
    sweep_check("collision", 5'd10, 5'd14, 5, 0);
    check("collision:write_fired", {63'd0, collide_fired}, 64'd1);
    exp_rf[12] = 32'hFFFF_0000;
    sweep_check("after_write", 5'd12, 5'd12, 1, 0);

    // Reset after three beats of a full sweep.
    got_idx.delete(); got_data.delete(); got_cyc.delete();
    cur_first = 5'd0; first_idx = 5'd0; last_idx = 5'd31; out_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 20 && got_idx.size() < 3; c++) tick();
    check("rst_mid:pre_beats", 64'(got_idx.size()), 64'd3);
    for (int k = 0; k < got_idx.size() && k < 3; k++) begin
      check("rst_mid:pre_idx", {59'd0, got_idx[k]}, 64'(k));
      check("rst_mid:pre_data", {32'd0, got_data[k]}, {32'd0, exp_rf[k]});
    end
    out_ready = 1'b0; rst = 1'b0;
    tick();
    rst = 1'b1; prev_stall = 1'b0;
    #1;
    check("rst_mid:out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_mid:busy", {63'd0, busy}, 64'd0);
    check("rst_mid:rsel", {59'd0, rsel}, 64'd0);
    check("rst_mid:out_data", {32'd0, out_data}, 64'd0);
    out_ready = 1'b1; done_cnt = 0;
    repeat (40) tick();
    check("rst_mid:no_done", 64'(done_cnt), 64'd0);
    check("rst_mid:no_more_beats", 64'(got_idx.size()), 64'd3);
    sweep_check("after_reset", 5'd7, 5'd7, 1, 0);

    sweep_check("start_busy", 5'd0, 5'd31, 32, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_reader.md
Name: regfile_reader

Overview:
- Sequential read-side engine for the RegisterFile's synchronous read port.
- On a start pulse it sweeps a contiguous, wrap-around range of register indices.
- It issues one read select per cycle and captures the one-cycle-latency read data.
- It streams (index, data) beats out over a valid/ready interface, for debug dump, context save and state compare.
- It is the reader counterpart to the writeback port that drives wsel/wdata/wen.

Parameters:
- XLEN, 32, register data width.
- NREGS, 32, number of architectural registers (power of two).
- IDX_W, $clog2(NREGS), index width.
- BUF_DEPTH, 2, output buffer entries (>=2).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous, active-low reset; the block is held in reset while rst==0 at posedge clk.
- start  input  1  one-cycle request to begin a sweep; ignored while busy.
- first_idx  input  IDX_W  first register index; sampled when start is accepted.
- last_idx  input  IDX_W  last register index, inclusive; sampled when start is accepted.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse after the final beat is accepted.
- rsel  output  IDX_W  read select to the RegisterFile read port.
- rdata  input  XLEN  RegisterFile read data, valid one cycle after rsel.
- out_valid  output  1  output beat valid.
- out_ready  input  1  consumer ready.
- out_idx  output  IDX_W  register index of the current beat.
- out_data  output  XLEN  register value of the current beat.

Behaviour:
- Reset values: busy=0, done=0, rsel=0, out_valid=0, out_idx=0, out_data=0. The FIFO is empty, counters are 0, and state is IDLE.
- Beat count: N = ((last_idx - first_idx) mod NREGS) + 1.
  - The index increments modulo NREGS, so first=30, last=1 yields 30, 31, 0, 1.
  - first==last yields exactly 1 beat. A full sweep of 32 requires last = first-1.
- States:
  - IDLE: start=1 latches the range, sets cur=first_idx and remaining=N, then goes to ISSUE.
  - ISSUE: a read is issued in any cycle where credits>0, with credits = BUF_DEPTH - fifo_count - inflight.
    - Issuing drives rsel=cur for that cycle, tags inflight with cur, then increments cur and decrements remaining.
    - When the last read is issued, go to DRAIN.
  - DRAIN: wait until inflight==0 and the FIFO is empty with the final beat accepted. Then pulse done for 1 cycle and return to IDLE.
- Read latency: the data for an rsel presented in cycle t is on rdata in cycle t+1. It is pushed into the FIFO together with its tagged index at the end of cycle t+1.
- First beat timing: with out_ready held high, out_valid rises no later than 2 cycles after start is accepted.
- Throughput: 1 beat/cycle sustained with out_ready=1, for BUF_DEPTH>=2.
- Hold rule: when no read is issued, rsel holds its last value. It never changes while an in-flight read is outstanding except to issue the next read.
- Output protocol:
  - out_valid/out_idx/out_data come from the FIFO head and stay stable while out_valid=1 and out_ready=0.
  - A beat transfers when out_valid && out_ready.
  - out_valid never depends combinationally on out_ready.
- Backpressure: with out_ready=0 indefinitely, at most BUF_DEPTH reads are ever issued. No data is lost or duplicated.
- Simultaneous events:
  - A FIFO push and pop in the same cycle keep the count unchanged.
  - A start in the same cycle as done is ignored; a new start is accepted only in IDLE.
- Write collision: if the writeback writes register k in the same cycle rsel==k, the beat carries the old value, matching RegisterFile read-old semantics.
- Register 0: reads through the port as normal and is expected to return 0.
- Reset mid-sweep: rst=0 at any posedge aborts the sweep.
  - The FIFO is flushed, in-flight reads are discarded, and all outputs return to reset values.
  - No done pulse is generated.

Decomposition:
- Shared package (rf_pkg): XLEN, NREGS, IDX_W, and typedef reg_idx_t / xlen_t. RegisterFile and the core use the same package.
- Sub-module regfile_reader_fifo: synchronous FIFO of {idx, data}, parameter BUF_DEPTH, with push, pop, count, full, empty, and synchronous active-low reset.
- Top module: FSM, index/remaining counters, and in-flight tracking.

Test Plan:
- Full dump: preload r1..r31 with 32'h1000_0000+i, start with first=0, last=31, out_ready=1 -> 32 beats in order, idx 0..31, data 0 then 32'h1000_0000+i; done 1 cycle after the last beat; no gaps after the first beat.
- Wrap range: first=30, last=1, with r30=32'hAAAA_0030, r31=32'h1234_5678, r1=32'hDEAD_BEEF -> beats idx 30, 31, 0, 1 with data 32'hAAAA_0030, 32'h1234_5678, 0, 32'hDEAD_BEEF; exactly 4 beats.
- Backpressure: first=5, last=9; toggle out_ready pseudo-randomly and hold it 0 for 10 cycles mid-sweep -> 5 beats in order, none lost or duplicated, out_data stable while stalled, never more than BUF_DEPTH reads outstanding.
- Collision: during a sweep write r12=32'hFFFF_0000 in the cycle rsel==12, with an old value of 32'hAAAA_5555 -> the beat for idx 12 carries 32'hAAAA_5555; a second sweep returns 32'hFFFF_0000.
- Reset mid-sweep: assert rst=0 for 1 cycle after 3 beats of a 0..31 sweep -> next cycle out_valid=0, busy=0, done never pulses; a fresh start with first=last=7 yields a single beat idx 7.
- Start while busy: pulse start with first=3, last=3 during a 0..31 sweep -> ignored; exactly 32 beats; busy=0 after done.
